// File: rtl/cmd_byte_parser_pkg.sv
// Shared constants and types for the host-link command parser: opcodes,
// default field widths (common with memory_interface) and the FSM state encoding.
package cmd_byte_parser_pkg;

    localparam int         DEF_KEY_WIDTH   = 64;
    localparam int         DEF_VALUE_WIDTH = 64;
    localparam int         DEF_TTL_WIDTH   = 32;

    localparam logic [7:0] DEF_OP_GET = 8'h01;
    localparam logic [7:0] DEF_OP_SET = 8'h02;

    typedef enum logic [2:0] {
        S_OP    = 3'd0,
        S_KEY   = 3'd1,
        S_VAL   = 3'd2,
        S_TTL   = 3'd3,
        S_ISSUE = 3'd4,
        S_WAIT  = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter must be able to hold the byte count of the widest field.
    function automatic int cnt_width(input int key_w, input int value_w, input int ttl_w);
        return $clog2(max3(key_w, value_w, ttl_w) / 8 + 1);
    endfunction

endpackage

// File: rtl/cmd_byte_parser_if.sv
// Byte-stream input, cache command output and status signals of the parser.
// master = parser side, slave = host link / memory_interface side.
interface cmd_byte_parser_if #(
    parameter int KEY_WIDTH   = 64,
    parameter int VALUE_WIDTH = 64,
    parameter int TTL_WIDTH   = 32
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_ready;

    logic                   cmd_valid;
    logic                   cmd_write;
    logic [KEY_WIDTH-1:0]   cmd_key;
    logic [VALUE_WIDTH-1:0] cmd_value;
    logic [TTL_WIDTH-1:0]   cmd_ttl;
    logic                   cmd_ready;
    logic                   txn_done;

    logic                   busy;
    logic                   err_opcode;

    modport master (
        input  in_valid, in_data, cmd_ready, txn_done,
        output in_ready, cmd_valid, cmd_write, cmd_key, cmd_value, cmd_ttl,
               busy, err_opcode
    );

    modport slave (
        output in_valid, in_data, cmd_ready, txn_done,
        input  in_ready, cmd_valid, cmd_write, cmd_key, cmd_value, cmd_ttl,
               busy, err_opcode
    );

endinterface

// File: rtl/cmd_byte_parser.sv
// Assembles opcode/key/value/TTL bytes into one cache command and holds it
// stable from issue until memory_interface reports the transaction done.
module cmd_byte_parser
    import cmd_byte_parser_pkg::*;
#(
    parameter int         KEY_WIDTH   = DEF_KEY_WIDTH,
    parameter int         VALUE_WIDTH = DEF_VALUE_WIDTH,
    parameter int         TTL_WIDTH   = DEF_TTL_WIDTH,
    parameter logic [7:0] OP_GET      = DEF_OP_GET,
    parameter logic [7:0] OP_SET      = DEF_OP_SET
) (
    input  logic              clk,
    input  logic              rst_n,
    cmd_byte_parser_if.master bus
);

    localparam int CNT_W = cnt_width(KEY_WIDTH, VALUE_WIDTH, TTL_WIDTH);

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_WIDTH / 8 - 1);
    localparam logic [CNT_W-1:0] VALUE_LAST = CNT_W'(VALUE_WIDTH / 8 - 1);
    localparam logic [CNT_W-1:0] TTL_LAST   = CNT_W'(TTL_WIDTH / 8 - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   write_q, write_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic [TTL_WIDTH-1:0]   ttl_q, ttl_d;

    logic                   in_ready;
    logic                   accept;

    // Ready depends on state only so the host link never sees a comb path back from in_valid.
    assign in_ready = (state_q != S_ISSUE) && (state_q != S_WAIT);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first; a path that
        // forgets to assign one would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        key_d   = key_q;
        value_d = value_q;
        ttl_d   = ttl_q;

        case (state_q)
            S_OP: begin
                if (accept) begin
                    if (bus.in_data == OP_GET || bus.in_data == OP_SET) begin
                        write_d = (bus.in_data == OP_SET);
                        key_d   = '0;
                        value_d = '0;
                        ttl_d   = '0;
                        cnt_d   = '0;
                        state_d = S_KEY;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_KEY: begin
                if (accept) begin
                    key_d = (key_q << 8) | KEY_WIDTH'(bus.in_data);
                    if (cnt_q == KEY_LAST) begin
                        cnt_d = '0;
                        if (write_q) begin
                            state_d = S_VAL;
                        end else begin
                            state_d = S_ISSUE;
                            valid_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_VAL: begin
                if (accept) begin
                    value_d = (value_q << 8) | VALUE_WIDTH'(bus.in_data);
                    if (cnt_q == VALUE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_TTL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_TTL: begin
                if (accept) begin
                    ttl_d = (ttl_q << 8) | TTL_WIDTH'(bus.in_data);
                    if (cnt_q == TTL_LAST) begin
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                // cmd_valid falls right after the handshake so the command is launched once.
                if (bus.cmd_ready) begin
                    valid_d = 1'b0;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.txn_done) begin
                    state_d = S_OP;
                end
            end

            default: begin
                valid_d = 1'b0;
                state_d = S_OP;
            end
        endcase
    end

    // NOTE: the command fields are reset along with the control state because
    // they are outputs that must read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OP;
            cnt_q   <= '0;
            write_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            key_q   <= '0;
            value_q <= '0;
            ttl_q   <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            key_q   <= key_d;
            value_q <= value_d;
            ttl_q   <= ttl_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.cmd_valid  = valid_q;
    assign bus.cmd_write  = write_q;
    assign bus.cmd_key    = key_q;
    assign bus.cmd_value  = value_q;
    assign bus.cmd_ttl    = ttl_q;
    assign bus.busy       = (state_q != S_OP);
    assign bus.err_opcode = err_q;

endmodule

// File: tb/tb_cmd_byte_parser.sv
// Self-checking bench for cmd_byte_parser: directed frame table, reset and
// back-to-back sequences, then random frames against a frame-level model.
module tb_cmd_byte_parser;
    import cmd_byte_parser_pkg::*;

    localparam int KEY_BYTES   = DEF_KEY_WIDTH / 8;
    localparam int VALUE_BYTES = DEF_VALUE_WIDTH / 8;
    localparam int TTL_BYTES   = DEF_TTL_WIDTH / 8;

    typedef struct {
        logic [7:0]  op;
        logic [63:0] key;
        logic [63:0] value;
        logic [31:0] ttl;
        int          max_gap;
        int          ready_delay;
        int          done_delay;
        logic        b2b;
        logic        exp_cmd;
        logic        exp_write;
        logic [63:0] exp_key;
        logic [63:0] exp_value;
        logic [31:0] exp_ttl;
    } vec_t;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;
    int exp_cmd_cnt;
    int exp_err_cnt;
    int mon_cmd_cnt;
    int mon_err_cnt;

    cmd_byte_parser_if bus ();

    cmd_byte_parser dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol-level observation: every issue handshake and every error cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cmd_valid && bus.cmd_ready) mon_cmd_cnt++;
            if (bus.err_opcode) mon_err_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, wanted %0b", name, act, exp);
        end
    endtask

    // Frame-level reference: which command a frame should produce.
    function automatic vec_t model(input logic [7:0] op, input logic [63:0] key,
                                   input logic [63:0] value, input logic [31:0] ttl);
        vec_t v;
        v = '{default: '0};
        v.op        = op;
        v.key       = key;
        v.value     = value;
        v.ttl       = ttl;
        v.exp_cmd   = (op == DEF_OP_GET) || (op == DEF_OP_SET);
        v.exp_write = (op == DEF_OP_SET);
        v.exp_key   = v.exp_cmd ? key : 64'h0;
        v.exp_value = v.exp_write ? value : 64'h0;
        v.exp_ttl   = v.exp_write ? ttl : 32'h0;
        return v;
    endfunction

    // Called and returns at posedge+1; waits = edges spent with in_valid high before acceptance.
    task automatic push_byte(input logic [7:0] b, input int max_gap, output int waits);
        int  gap;
        logic acc;
        gap   = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        waits = 0;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        forever begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waits++;
            if (waits > 100) begin
                check("byte_accept_timeout", 64'(waits), 64'd0);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int   w;
        logic stall_ok;
        logic wait_ok;

        push_byte(v.op, v.b2b ? 0 : v.max_gap, w);
        if (v.b2b) check("b2b_opcode_wait", 64'(w), 64'd0);
        check_bit("err_opcode_pulse", bus.err_opcode, !v.exp_cmd);
        check_bit("busy_after_opcode", bus.busy, v.exp_cmd);
        if (!v.exp_cmd) begin
            exp_err_cnt++;
            @(posedge clk);
            #1;
            check_bit("err_opcode_single", bus.err_opcode, 1'b0);
            return;
        end

        for (int i = KEY_BYTES - 1; i >= 0; i--) begin
            push_byte(v.key[i*8 +: 8], v.max_gap, w);
            if (i == 1) check_bit("valid_before_last_key", bus.cmd_valid, 1'b0);
        end
        if (v.exp_write) begin
            for (int i = VALUE_BYTES - 1; i >= 0; i--) push_byte(v.value[i*8 +: 8], v.max_gap, w);
            check_bit("valid_before_ttl", bus.cmd_valid, 1'b0);
            for (int i = TTL_BYTES - 1; i >= 0; i--) push_byte(v.ttl[i*8 +: 8], v.max_gap, w);
        end
        exp_cmd_cnt++;

        check_bit("cmd_valid_latency", bus.cmd_valid, 1'b1);
        check_bit("cmd_write", bus.cmd_write, v.exp_write);
        check("cmd_key", bus.cmd_key, v.exp_key);
        check("cmd_value", bus.cmd_value, v.exp_value);
        check("cmd_ttl", 64'(bus.cmd_ttl), 64'(v.exp_ttl));
        check_bit("in_ready_issue", bus.in_ready, 1'b0);

        // Stall: bytes offered and stray txn_done must both be ignored.
        stall_ok     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = DEF_OP_SET;
        for (int c = 0; c < v.ready_delay; c++) begin
            bus.txn_done = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
            if (!bus.cmd_valid || bus.in_ready) stall_ok = 1'b0;
        end
        bus.txn_done = 1'b0;
        bus.in_valid = 1'b0;
        check_bit("stall_hold", stall_ok, 1'b1);

        bus.cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_ready = 1'b0;
        check_bit("cmd_valid_drop", bus.cmd_valid, 1'b0);

        wait_ok = 1'b1;
        for (int c = 0; c < v.done_delay; c++) begin
            bus.cmd_ready = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
            if (bus.cmd_valid || !bus.busy || bus.in_ready) wait_ok = 1'b0;
        end
        bus.cmd_ready = 1'b0;
        check_bit("wait_state_hold", wait_ok, 1'b1);
        check("held_key", bus.cmd_key, v.exp_key);
        check("held_value", bus.cmd_value, v.exp_value);
        check("held_ttl", 64'(bus.cmd_ttl), 64'(v.exp_ttl));
        check_bit("held_write", bus.cmd_write, v.exp_write);

        bus.txn_done = 1'b1;
        @(posedge clk);
        #1;
        bus.txn_done = 1'b0;
        check_bit("idle_after_done", bus.busy, 1'b0);
        check_bit("in_ready_after_done", bus.in_ready, 1'b1);
    endtask

    vec_t vecs[7];
    vec_t rv;
    logic [7:0] rop;
    int         w;

    initial begin
        n_cmp = 0; n_err = 0;
        exp_cmd_cnt = 0; exp_err_cnt = 0;
        mon_cmd_cnt = 0; mon_err_cnt = 0;

        //        op     key                     value                   ttl           gap rdy done b2b cmd wr  exp_key                 exp_value               exp_ttl
        vecs[0] = '{8'h01, 64'h0011223344556677, 64'h0,                  32'h0,        0,  0,  0,   0,  1,  0,  64'h0011223344556677, 64'h0,                  32'h0};
        vecs[1] = '{8'h02, 64'h00000000000000A5, 64'hDEADBEEFCAFEF00D,   32'd1000,     0,  0,  2,   0,  1,  1,  64'h00000000000000A5, 64'hDEADBEEFCAFEF00D,   32'd1000};
        vecs[2] = '{8'h7F, 64'h0,                64'h0,                  32'h0,        0,  0,  0,   0,  0,  0,  64'h0,                64'h0,                  32'h0};
        vecs[3] = '{8'h01, 64'hFEDCBA9876543210, 64'h1111111111111111,   32'h22222222, 2,  0,  0,   0,  1,  0,  64'hFEDCBA9876543210, 64'h0,                  32'h0};
        vecs[4] = '{8'h02, 64'hFFFFFFFFFFFFFFFF, 64'h0,                  32'hFFFFFFFF, 1,  5,  1,   0,  1,  1,  64'hFFFFFFFFFFFFFFFF, 64'h0,                  32'hFFFFFFFF};
        vecs[5] = '{8'h02, 64'h0102030405060708, 64'h1020304050607080,   32'h0A0B0C0D, 0,  0,  2,   0,  1,  1,  64'h0102030405060708, 64'h1020304050607080,   32'h0A0B0C0D};
        vecs[6] = '{8'h02, 64'h8070605040302010, 64'h0F0E0D0C0B0A0908,   32'hD0C0B0A0, 0,  1,  2,   1,  1,  1,  64'h8070605040302010, 64'h0F0E0D0C0B0A0908,   32'hD0C0B0A0};

        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.cmd_ready = 1'b0;
        bus.txn_done  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check_bit("reset_in_ready", bus.in_ready, 1'b1);
        check_bit("reset_cmd_valid", bus.cmd_valid, 1'b0);
        check_bit("reset_busy", bus.busy, 1'b0);
        check_bit("reset_err", bus.err_opcode, 1'b0);
        check("reset_key", bus.cmd_key, 64'h0);

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Async reset mid-key: partial frame must vanish.
        push_byte(DEF_OP_SET, 0, w);
        for (int i = 7; i >= 4; i--) push_byte(8'hC0 + 8'(i), 0, w);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("midreset_busy", bus.busy, 1'b0);
        check_bit("midreset_in_ready", bus.in_ready, 1'b1);
        check_bit("midreset_write", bus.cmd_write, 1'b0);
        check("midreset_key", bus.cmd_key, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(model(DEF_OP_GET, 64'h0000000000001234, 64'h0, 32'h0));

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(9, 0))
                0:       begin
                    rop = 8'($urandom_range(255, 3));
                end
                1, 2, 3, 4: rop = DEF_OP_GET;
                default: rop = DEF_OP_SET;
            endcase
            rv = model(rop, {$urandom(), $urandom()}, {$urandom(), $urandom()}, $urandom());
            rv.max_gap     = int'($urandom_range(3, 0));
            rv.ready_delay = int'($urandom_range(4, 0));
            rv.done_delay  = int'($urandom_range(4, 0));
            rv.b2b         = 1'($urandom_range(1, 0));
            run_frame(rv);
        end

        repeat (2) @(posedge clk);
        #1;
        check("issued_commands", 64'(mon_cmd_cnt), 64'(exp_cmd_cnt));
        check("err_opcode_cycles", 64'(mon_err_cnt), 64'(exp_err_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
